serial_code_decoder: RTL

- Receives 4-bit code words serially from the line side, one bit per clock under a valid strobe.
- Inverts the team's 4-bit code-conversion mapping and presents the recovered ABCD nibble on a registered output port with a valid/ready handshake.
- Sits downstream of the code-conversion encoder, at the opposite end of the code link.
- Keeps a running count of delivered words and optionally checks a per-frame parity bit.

---
 rtl/serial_code_decoder_if.sv | 36 +++
 rtl/serial_code_decoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_code_decoder_if.sv
// Line-side serial input and word-side valid/ready output bundle for serial_code_decoder.
`timescale 1ns/1ps
interface serial_code_decoder_if #(
    parameter int CNT_W = 8
) ();
    logic             ser_in;
    logic             ser_valid;
    logic             in_ready;
    logic [3:0]       data_out;
    logic             out_valid;
    logic             out_ready;
    logic             par_err;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output ser_in,
        output ser_valid,
        input  in_ready,
        input  data_out,
        input  out_valid,
        output out_ready,
        input  par_err,
        input  word_cnt
    );

    modport slave (
        input  ser_in,
        input  ser_valid,
        output in_ready,
        output data_out,
        output out_valid,
        input  out_ready,
        output par_err,
        output word_cnt
    );
endinterface

// File: rtl/serial_code_decoder.sv
// Serial 4-bit code-word decoder with registered valid/ready output and delivered-word counter.
// Define DECODER_PARITY_EN to add a trailing odd-parity bit P to each frame.
`timescale 1ns/1ps
module serial_code_decoder #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_code_decoder_if.slave bus
);

`ifdef DECODER_PARITY_EN
    localparam int unsigned LAST_IDX = 4;
`else
    localparam int unsigned LAST_IDX = 3;
`endif
    // Only the bits preceding the last one need storing; the last bit is used straight off the line.
    localparam int unsigned SR_W = LAST_IDX;

    typedef enum logic {
        SHIFT,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [3:0]       data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             par_err_q, par_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [3:0]       frame_code;
    logic             frame_par_err;

`ifdef DECODER_PARITY_EN
    assign frame_code    = sr_q;
    assign frame_par_err = ~(^{sr_q, bus.ser_in});
`else
    assign frame_code    = {sr_q, bus.ser_in};
    assign frame_par_err = 1'b0;
`endif

    function automatic logic [3:0] decode_code(input logic [3:0] code);
        logic [3:0] val;
        case (code)
            4'b0101: val = 4'd0;
            4'b1100: val = 4'd1;
            4'b1001: val = 4'd2;
            4'b0000: val = 4'd3;
            4'b0001: val = 4'd4;
            4'b1111: val = 4'd5;
            4'b0100: val = 4'd6;
            4'b1011: val = 4'd7;
            4'b0111: val = 4'd8;
            4'b0011: val = 4'd9;
            4'b1101: val = 4'd10;
            4'b0010: val = 4'd11;
            4'b1110: val = 4'd12;
            4'b1000: val = 4'd13;
            4'b0110: val = 4'd14;
            default: val = 4'd15;
        endcase
        return val;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SHIFT;
            bit_idx_q   <= '0;
            sr_q        <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            sr_q        <= sr_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            par_err_q   <= par_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        sr_d        = sr_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        par_err_d   = par_err_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            SHIFT: begin
                if (bus.ser_valid) begin
                    if (bit_idx_q == 3'(LAST_IDX)) begin
                        data_out_d  = decode_code(frame_code);
                        par_err_d   = frame_par_err;
                        out_valid_d = 1'b1;
                        bit_idx_d   = '0;
                        state_d     = HOLD;
                    end else begin
                        sr_d      = {sr_q[SR_W-2:0], bus.ser_in};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    state_d     = SHIFT;
                end
            end
            default: state_d = SHIFT;
        endcase
    end

    assign bus.in_ready  = (state_q == SHIFT);
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.word_cnt  = word_cnt_q;

endmodule
